mul_seq_param: RTL and testbench

//   Parametrised iterative multiplier for the EX-stage MULT/MULTU path. It multiplies two

---
 rtl/mul_seq_param.sv | 151 +++++++++++++++
 tb/tb_mul_seq_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// Iterative WIDTH x WIDTH multiplier retiring STEP multiplier bits per clock.
// Operands are reduced to magnitudes at start; the product sign is restored on the final edge.
module mul_seq_param #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_mul_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    // state | meaning
    // IDLE  | waiting for start_i (annul_i masks a request)
    // CALC  | one STEP-bit iteration per edge, busy_o high
    // DONE  | result_o valid, ready_o high until start_i drops or annul_i
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_finish;
    logic                  w_abort;
    logic                  w_done_exit;

    logic                  r_sgn;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [2*WIDTH-1:0]    r_acc;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_result;
    logic                  r_ready;
    logic                  r_busy;

    logic [WIDTH-1:0]      w_op1_mag;
    logic [WIDTH-1:0]      w_op2_mag;
    logic [2*WIDTH-1:0]    w_pp;
    logic [2*WIDTH-1:0]    w_acc_next;

    // The most negative value negates to itself, which is already its unsigned magnitude.
    assign w_op1_mag = (signed_mul_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_op2_mag = (signed_mul_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    always_comb begin
        w_pp = '0;
        for (int k = 0; k < STEP; k++) begin
            if (r_mplier[k]) begin
                w_pp = w_pp + (r_mcand << k);
            end
        end
    end

    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        w_done_exit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    w_state_next = CALC;
                    w_accept     = 1'b1;
                end
            end
            CALC: begin
                if (annul_i) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_state_next = DONE;
                    w_finish     = 1'b1;
                end
            end
            DONE: begin
                if (annul_i || !start_i) begin
                    w_state_next = IDLE;
                    w_done_exit  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sgn    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sgn    <= signed_mul_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                r_mcand  <= {{WIDTH{1'b0}}, w_op1_mag};
                r_mplier <= w_op2_mag;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (w_abort) begin
                r_busy   <= 1'b0;
            end else if (r_state == CALC) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << STEP;
                r_mplier <= r_mplier >> STEP;
                r_cnt    <= r_cnt + CW'(1);
                if (w_finish) begin
                    r_result <= r_sgn ? -w_acc_next : w_acc_next;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            end else if (w_done_exit) begin
                r_ready  <= 1'b0;
            end
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: four 32-bit instances (STEP 1/2/4/8) and one 16-bit STEP 2
// instance share the handshake; expected products go through a scoreboard queue.
module tb_mul_seq_param;

    logic        clk;
    logic        rst;
    logic        signed_mul;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;

    logic [63:0] res [4];
    logic [3:0]  rdy;
    logic [3:0]  bsy;
    logic [31:0] res_h;
    logic        rdy_h;
    logic        bsy_h;

    int checks = 0;
    int errors = 0;
    int lat_exp [4] = '{32, 16, 8, 4};

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
    } vec_t;

    typedef struct {
        logic [63:0] e32;
        logic [31:0] e16;
    } exp_t;

    exp_t sb [$];

    mul_seq_param #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .signed_mul_i(signed_mul), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(res[0]), .ready_o(rdy[0]), .busy_o(bsy[0]));
    mul_seq_param #(.WIDTH(32), .STEP(2)) u_s2 (
        .clk(clk), .rst(rst), .signed_mul_i(signed_mul), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(res[1]), .ready_o(rdy[1]), .busy_o(bsy[1]));
    mul_seq_param #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .signed_mul_i(signed_mul), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(res[2]), .ready_o(rdy[2]), .busy_o(bsy[2]));
    mul_seq_param #(.WIDTH(32), .STEP(8)) u_s8 (
        .clk(clk), .rst(rst), .signed_mul_i(signed_mul), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(res[3]), .ready_o(rdy[3]), .busy_o(bsy[3]));
    mul_seq_param #(.WIDTH(16), .STEP(2)) u_h (
        .clk(clk), .rst(rst), .signed_mul_i(signed_mul), .opdata1_i(op1[15:0]), .opdata2_i(op2[15:0]),
        .start_i(start), .annul_i(annul), .result_o(res_h), .ready_o(rdy_h), .busy_o(bsy_h));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref32(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb64;
        if (sg) begin
            sa   = {{32{a[31]}}, a};
            sb64 = {{32{b[31]}}, b};
            return sa * sb64;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] ref16(input logic sg, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb32;
        if (sg) begin
            sa   = {{16{a[15]}}, a};
            sb32 = {{16{b[15]}}, b};
            return sa * sb32;
        end
        return {16'b0, a} * {16'b0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] e32, input string tag);
        exp_t        e;
        int          lat [5];
        logic [31:0] held;
        bit          all_seen;
        e.e32 = e32;
        e.e16 = ref16(sg, a[15:0], b[15:0]);
        sb.push_back(e);
        for (int i = 0; i < 5; i++) lat[i] = -1;
        held = '0;
        @(negedge clk);
        signed_mul = sg;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        op1        = $urandom;
        op2        = $urandom;
        signed_mul = ~sg;
        all_seen   = 1'b0;
        for (int k = 1; k <= 40 && !all_seen; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (rdy[i] && lat[i] < 0) lat[i] = k;
            if (lat[4] >= 0) begin
                chk({tag, " h_hold_res"}, {32'b0, res_h}, {32'b0, held});
                chk({tag, " h_hold_rdy"}, {63'b0, rdy_h}, 64'd1);
            end else if (rdy_h) begin
                lat[4] = k;
                held   = res_h;
            end
            all_seen = 1'b1;
            for (int i = 0; i < 5; i++) if (lat[i] < 0) all_seen = 1'b0;
        end
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s lat%0d", tag, i), 64'(lat[i]), 64'(lat_exp[i]));
            chk($sformatf("%s res%0d", tag, i), res[i], e.e32);
        end
        chk({tag, " h_lat"}, 64'(lat[4]), 64'd8);
        chk({tag, " h_res"}, {32'b0, res_h}, {32'b0, e.e16});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " rdy_drop"}, {59'b0, rdy_h, rdy}, 64'd0);
        chk({tag, " busy_idle"}, {59'b0, bsy_h, bsy}, 64'd0);
        chk({tag, " res_kept"}, res[0], e.e32);
        chk({tag, " h_res_kept"}, {32'b0, res_h}, {32'b0, e.e16});
    endtask

    vec_t vecs [6];

    initial begin
        logic [63:0] prior;
        bit          seen_rdy;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2] = '{1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 64'h0000_0000_0000_0015};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 64'h0000_0000_0000_0000};

        rst        = 1'b0;
        signed_mul = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        #12;
        chk("reset_res0", res[0], 64'd0);
        chk("reset_res3", res[3], 64'd0);
        chk("reset_flags", {54'b0, rdy_h, bsy_h, rdy, bsy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].sg, vecs[v].a, vecs[v].b, vecs[v].e, $sformatf("vec%0d", v));
        end

        // annul part-way through the STEP=1 calculation
        prior = res[0];
        @(negedge clk);
        signed_mul = 1'b0;
        op1        = 32'h1234_5678;
        op2        = 32'h9ABC_DEF0;
        start      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("annul_busy_before", {63'b0, bsy[0]}, 64'd1);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_busy", {63'b0, bsy[0]}, 64'd0);
        chk("annul_rdy", {63'b0, rdy[0]}, 64'd0);
        chk("annul_res", res[0], prior);
        @(negedge clk);
        annul    = 1'b0;
        seen_rdy = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rdy[0]) seen_rdy = 1'b1;
        end
        chk("annul_no_rdy", {63'b0, seen_rdy}, 64'd0);
        chk("annul_res_later", res[0], prior);
        run_txn(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, ref32(1'b0, 32'h1234_5678, 32'h9ABC_DEF0), "post_annul");

        // async reset between edges mid-calculation
        @(negedge clk);
        signed_mul = 1'b1;
        op1        = 32'hDEAD_BEEF;
        op2        = 32'h0000_0123;
        start      = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_res0", res[0], 64'd0);
        chk("arst_res3", res[3], 64'd0);
        chk("arst_res_h", {32'b0, res_h}, 64'd0);
        chk("arst_flags", {54'b0, rdy_h, bsy_h, rdy, bsy}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_txn(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, ref32(1'b1, 32'hDEAD_BEEF, 32'h0000_0123), "post_rst");

        for (int r = 0; r < 20; r++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            if (r % 5 == 0) a = 32'h8000_0000;
            run_txn(sg, a, b, ref32(sg, a, b), $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
